// File: rtl/rand_index_sel_if.sv
// Request/result bundle between the index selector and its requester.
// The requester also forwards the LFSR word here.
interface rand_index_sel_if #(parameter int IDX_W = 10);
  logic [15:0]    rand_in;
  logic           start;
  logic [IDX_W:0] n_count;
  logic           excl_en;
  logic [IDX_W-1:0] excl_idx;
  logic [IDX_W-1:0] idx;
  logic           idx_valid;
  logic           idx_ready;
  logic           fallback;
  logic           err;
  logic           busy;

  modport master (
    output rand_in, start, n_count, excl_en, excl_idx, idx_ready,
    input  idx, idx_valid, fallback, err, busy
  );

  modport slave (
    input  rand_in, start, n_count, excl_en, excl_idx, idx_ready,
    output idx, idx_valid, fallback, err, busy
  );
endinterface

// File: rtl/rand_index_sel.sv
// Uniform index picker over [0, n_count) by masked rejection sampling of an
// LFSR word, with optional exclusion and a deterministic fallback after MAX_TRIES rejects.
module rand_index_sel #(
  parameter int IDX_W     = 10,
  parameter int MAX_TRIES = 64
) (
  input logic            clk,
  input logic            rst,
  rand_index_sel_if.slave sel
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W:0]   n_q, n_d;
  logic             excl_en_q, excl_en_d;
  logic [IDX_W-1:0] excl_idx_q, excl_idx_d;
  logic [IDX_W-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fb_q, fb_d;
  logic             err_q, err_d;
  logic             err_pend_q, err_pend_d;
  logic [TW-1:0]    tries_q, tries_d;

  logic [IDX_W:0]   nm1;
  logic [IDX_W-1:0] mask_new;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   excl_p1;
  logic [IDX_W-1:0] fb_val;
  logic             accept;
  logic             impossible;

  generate
    if (IDX_W < 16) begin : g_unused
      logic unused_rand_hi;
      assign unused_rand_hi = ^sel.rand_in[15:IDX_W];
    end
  endgenerate

  // Smear the highest set bit of n_count-1 downwards to get the draw mask.
  always_comb begin
    nm1 = sel.n_count - (IDX_W+1)'(1);
    mask_new = '0;
    for (int i = 0; i < IDX_W; i++) mask_new[i] = |(nm1 >> i);
  end

  assign impossible = (sel.n_count == '0) ||
                      (sel.n_count == (IDX_W+1)'(1) && sel.excl_en && sel.excl_idx == '0);
  assign cand    = sel.rand_in[IDX_W-1:0] & mask_q;
  assign accept  = ({1'b0, cand} < n_q) && !(excl_en_q && cand == excl_idx_q);
  assign excl_p1 = {1'b0, excl_idx_q} + (IDX_W+1)'(1);
  assign fb_val  = (excl_en_q && excl_p1 < n_q) ? excl_p1[IDX_W-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    excl_en_d  = excl_en_q;
    excl_idx_d = excl_idx_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    fb_d       = fb_q;
    err_d      = err_q;
    err_pend_d = err_pend_q;
    tries_d    = tries_q;
    case (state_q)
      IDLE: if (sel.start) begin
        n_d        = sel.n_count;
        excl_en_d  = sel.excl_en;
        excl_idx_d = sel.excl_idx;
        mask_d     = mask_new;
        err_pend_d = impossible;
        tries_d    = '0;
        state_d    = DRAW;
      end
      DRAW: begin
        // Impossible requests spend one DRAW cycle so err shares the k=1 latency.
        if (err_pend_q) begin
          idx_d   = '0;
          fb_d    = 1'b0;
          err_d   = 1'b1;
          state_d = HOLD;
        end else if (accept) begin
          idx_d   = cand;
          fb_d    = 1'b0;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          idx_d   = fb_val;
          fb_d    = 1'b1;
          err_d   = 1'b0;
          state_d = HOLD;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      HOLD: if (sel.idx_ready) begin
        tries_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      excl_en_q  <= 1'b0;
      excl_idx_q <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      fb_q       <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      tries_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      excl_en_q  <= excl_en_d;
      excl_idx_q <= excl_idx_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      fb_q       <= fb_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      tries_q    <= tries_d;
    end
  end

  assign sel.idx       = idx_q;
  assign sel.idx_valid = (state_q == HOLD);
  assign sel.busy      = (state_q != IDLE);
  assign sel.fallback  = fb_q;
  assign sel.err       = err_q;
endmodule

// File: tb/tb_rand_index_sel.sv
// Directed scoreboard bench for rand_index_sel (IDX_W=10, MAX_TRIES=64).
module tb_rand_index_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rand_index_sel_if #(.IDX_W(10)) sel();

  rand_index_sel #(.IDX_W(10), .MAX_TRIES(64)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel)
  );

  typedef struct {
    logic [9:0] idx;
    logic       fb;
    logic       err;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rq[$];
  int vecs = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_rand();
    if (rq.size() > 0) sel.rand_in = rq.pop_front();
  endtask

  task automatic expect_res(input logic [9:0] idx, input logic fb, input logic err, input int lat);
    exp_t e;
    e.idx = idx; e.fb = fb; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Start a request, then scramble the request inputs to show they are not re-sampled.
  task automatic req(input int n, input logic een, input logic [9:0] eidx);
    @(negedge clk);
    sel.start    = 1'b1;
    sel.n_count  = 11'(n);
    sel.excl_en  = een;
    sel.excl_idx = eidx;
    @(negedge clk);
    sel.start    = 1'b0;
    next_rand();
    chk("busy_after_start", sel.busy, 1);
    sel.n_count  = 11'd0;
    sel.excl_en  = ~een;
    sel.excl_idx = ~eidx;
  endtask

  task automatic collect(input bit ack);
    int   k;
    exp_t e;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (sel.idx_valid || k >= 200) break;
      next_rand();
    end
    chk("valid_within_bound", sel.idx_valid, 1);
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sel.idx_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("idx", sel.idx, e.idx);
      chk("fallback", sel.fallback, e.fb);
      chk("err", sel.err, e.err);
      chk("latency", k, e.lat);
      if (ack) begin
        sel.idx_ready = 1'b1;
        @(negedge clk);
        sel.idx_ready = 1'b0;
        chk("valid_cleared", sel.idx_valid, 0);
        chk("busy_cleared", sel.busy, 0);
        chk("idx_retained", sel.idx, e.idx);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_idx"}, sel.idx, 0);
    chk({tag, "_valid"}, sel.idx_valid, 0);
    chk({tag, "_fb"}, sel.fallback, 0);
    chk({tag, "_err"}, sel.err, 0);
    chk({tag, "_busy"}, sel.busy, 0);
  endtask

  initial begin
    sel.rand_in = 16'h0; sel.start = 1'b0; sel.n_count = '0;
    sel.excl_en = 1'b0; sel.excl_idx = '0; sel.idx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    rq = '{16'h0007};               expect_res(10'd7, 0, 0, 1);    req(10, 0, 0); collect(1);
    rq = '{16'h000C, 16'h000F, 16'h0003}; expect_res(10'd3, 0, 0, 3); req(10, 0, 0); collect(1);
    rq = '{16'h0002, 16'h0001};     expect_res(10'd1, 0, 0, 2);    req(4, 1, 2);  collect(1);
    rq = '{16'h0007};               expect_res(10'd4, 1, 0, 64);   req(5, 1, 3);  collect(1);
    expect_res(10'd0, 1, 0, 64);    req(5, 1, 4);  collect(1);
    rq = '{16'hFFFF};               expect_res(10'd1023, 0, 0, 1); req(1024, 0, 0); collect(1);
    expect_res(10'd0, 0, 1, 1);     req(0, 0, 0);  collect(1);
    rq = '{16'h0005};               expect_res(10'd5, 0, 0, 1);    req(10, 0, 0); collect(1);
    expect_res(10'd0, 0, 1, 1);     req(1, 1, 0);  collect(1);
    rq = '{16'h0003};               expect_res(10'd3, 0, 0, 1);    req(4, 1, 9);  collect(1);
    rq = '{16'hFFFF};               expect_res(10'd0, 0, 0, 1);    req(1, 0, 0);  collect(1);

    // Stall in HOLD with start pulsing: result must stay put and start must not queue.
    rq = '{16'h0005};               expect_res(10'd5, 0, 0, 1);    req(10, 0, 0); collect(0);
    for (int i = 0; i < 5; i++) begin
      sel.start = 1'b1; sel.n_count = 11'd3; sel.excl_en = 1'b0;
      @(negedge clk);
      chk("hold_idx", sel.idx, 5);
      chk("hold_valid", sel.idx_valid, 1);
      chk("hold_busy", sel.busy, 1);
    end
    sel.idx_ready = 1'b1;
    @(negedge clk);
    sel.idx_ready = 1'b0;
    sel.start = 1'b0;
    chk("exit_busy", sel.busy, 0);
    chk("exit_valid", sel.idx_valid, 0);
    @(negedge clk);
    chk("start_not_queued", sel.busy, 0);

    // Reset in the middle of a long reject run.
    rq = '{16'h0007}; req(5, 1, 3);
    repeat (3) @(negedge clk);
    chk("draw_busy", sel.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_draw");

    // Reset while a result is held.
    rq = '{16'h0009}; expect_res(10'd9, 0, 0, 1); req(10, 0, 0); collect(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_hold");

    rq = '{16'h0026}; expect_res(10'd6, 0, 0, 1); req(10, 0, 0); collect(1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
